rv32i_mc_control: RTL
=====================

# rv32i_mc_control

Multi-cycle control FSM for the RV32I core. It sequences one shared datapath (ALU, register file, immediate sign-extender, unified memory port) through fetch, decode, execute, memory and write-back steps. Per state it drives the immediate-format select into the sign-extend unit, the mux selects and the write enables, and it handshakes with a variable-latency memory. It sits beside the datapath and is its only source of control.

## Interface
- No parameters.
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- IR  in  32  instruction register contents (valid from DECODE onward)
- br_taken  in  1  branch comparator result for current funct3
- mem_ready  in  1  memory completes the current request this cycle
- Mem_Req  out  1  memory request, held until mem_ready
- Mem_Write  out  1  request is a store
- IorD  out  1  memory address: 0 = PC, 1 = ALU result register
- IR_Write  out  1  latch memory data into IR; datapath copies PC into OldPC on the same edge
- PC_Write  out  1  update PC
- PC_Src  out  1  0 = ALU result (PC+4), 1 = ALU result (target)
- RegWrite  out  1  register-file write enable
- SE_Control  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J
- ALU_SrcA  out  2  0 = PC, 1 = OldPC, 2 = rs1, 3 = zero
- ALU_SrcB  out  2  0 = rs2, 1 = imm, 2 = constant 4
- ALU_Op  out  2  0 = add, 1 = compare, 2 = funct3/funct7-decoded
- WB_Sel  out  2  0 = ALU result, 1 = memory data, 2 = OldPC+4
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  sticky: unsupported opcode seen

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: entered by reset, all outputs 0, goes to FETCH next cycle.
- FETCH: Mem_Req=1, IorD=0, ALU PC+4.
  - Stays in FETCH until mem_ready.
  - On mem_ready: IR_Write=1, PC_Write=1, PC_Src=0, then DECODE.
- DECODE: register read. SE_Control is set from IR[6:0] and held until the instruction retires.
- EXEC, by opcode:
  - R 0110011 / I-ALU 0010011: rs1 op rs2/imm, ALU_Op=2, then WB.
  - LOAD 0000011 / STORE 0100011: rs1+imm, then MEM.
  - BRANCH 1100011: compare; if br_taken, PC_Write=1 with target OldPC+imm; then FETCH with retire=1.
  - JAL 1101111: OldPC+imm. JALR 1100111: (rs1+imm) with bit 0 cleared. Both assert PC_Write, then WB with WB_Sel=2.
  - LUI 0110111: zero+imm. AUIPC 0010111: OldPC+imm. Both then WB.
- DECODE with FENCE 0001111 or SYSTEM 1110011: treated as NOP, goes to FETCH with retire=1.
- DECODE with any other opcode: goes to TRAP and sets illegal. TRAP holds, with all enables 0, until reset.
- MEM: Mem_Req=1, IorD=1, Mem_Write=1 for a store. Stays in MEM until mem_ready.
  - Load: then WB.
  - Store: retire=1, then FETCH.
- WB: RegWrite=1 (forced 0 when rd=0), retire=1, then FETCH.

## Timing
- Outputs are a Moore decode of state. Exceptions: EXEC PC_Write depends on br_taken; FETCH/MEM IR_Write and PC_Write and MEM retire depend on mem_ready.
- Minimum cycles per instruction, with mem_ready=1 on the first request cycle:
  - ALU, LUI, AUIPC, JAL, JALR: 4
  - Load: 5
  - Store: 4
  - Branch: 3
  - NOP: 2
- Each wait cycle on mem_ready adds one cycle.
- Mem_Req, Mem_Write and IorD stay stable from the first cycle Mem_Req is high until the cycle mem_ready is seen. mem_ready is ignored in all other states.
- Asynchronous reset at any point, including mid-MEM: state goes to IDLE and all outputs drop to 0 immediately. An outstanding memory request is abandoned.

## Structure
- Shared package rv32i_pkg holds:
  - opcode localparams
  - SE_Control codes 0–4
  - ALU_Op, ALU_SrcA/B and WB_Sel encodings
  - the state enum
- One combinational sub-module, rv32i_opcode_class. It maps IR[6:0] to an instruction class and an immediate format, and flags illegal opcodes.

## Test plan
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 -> states FETCH, DECODE, EXEC, WB; SE_Control=0; RegWrite=1 in cycle 4; retire once.
- LW with mem_ready low for 3 cycles in MEM -> Mem_Req and IorD=1 held 4 cycles; WB_Sel=1; 8 cycles total.
- BEQ (SE_Control=2):
  - br_taken=1 -> PC_Write=1 and PC_Src=1 in EXEC.
  - br_taken=0 -> no PC_Write in EXEC.
  - 3 cycles either way.
- JAL (SE_Control=4) -> PC_Write in EXEC; RegWrite with WB_Sel=2 in WB. SW (SE_Control=1) -> Mem_Write=1 and no RegWrite.
- Opcode 0x7F -> TRAP, illegal=1 and stays high; no further Mem_Req until rst_n pulse; after reset, IDLE then FETCH.
- rst_n low mid-MEM -> all outputs 0 the same cycle; FETCH two cycles after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle core: opcodes, control-field
// encodings, the controller state set and the instruction classes.
package rv32i_pkg;

  // Base opcodes (IR[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Immediate format select for the sign-extend unit
  localparam logic [2:0] SE_I = 3'd0;
  localparam logic [2:0] SE_S = 3'd1;
  localparam logic [2:0] SE_B = 3'd2;
  localparam logic [2:0] SE_U = 3'd3;
  localparam logic [2:0] SE_J = 3'd4;

  // ALU operation
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // ALU operand A source
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  // ALU operand B source
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // Register-file write-back source
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_IALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC,
    C_NOP,
    C_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/rv32i_mc_control_if.sv
// Memory-port handshake between the controller and the unified memory.
interface rv32i_mc_control_if;
  logic Mem_Req;
  logic Mem_Write;
  logic IorD;
  logic mem_ready;

  modport master (output Mem_Req, Mem_Write, IorD, input mem_ready);
  modport slave  (input Mem_Req, Mem_Write, IorD, output mem_ready);
endinterface

// File: rtl/rv32i_opcode_class.sv
// Combinational opcode classifier: instruction class, immediate format and
// an illegal-opcode flag from IR[6:0].
module rv32i_opcode_class
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic [2:0] imm_fmt,
  output logic       bad_op
);

  // Opcode lookup; R-type and NOPs carry no immediate, so they report I
  always_comb begin
    iclass  = C_ILLEGAL;
    imm_fmt = SE_I;
    bad_op  = 1'b0;
    case (opcode)
      OP_R:      iclass = C_R;
      OP_IALU:   iclass = C_IALU;
      OP_LOAD:   iclass = C_LOAD;
      OP_STORE:  begin iclass = C_STORE;  imm_fmt = SE_S; end
      OP_BRANCH: begin iclass = C_BRANCH; imm_fmt = SE_B; end
      OP_JAL:    begin iclass = C_JAL;    imm_fmt = SE_J; end
      OP_JALR:   iclass = C_JALR;
      OP_LUI:    begin iclass = C_LUI;    imm_fmt = SE_U; end
      OP_AUIPC:  begin iclass = C_AUIPC;  imm_fmt = SE_U; end
      OP_FENCE,
      OP_SYSTEM: iclass = C_NOP;
      default:   bad_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_control.sv
// Multi-cycle control FSM for the RV32I core. Sequences the shared datapath
// through fetch/decode/execute/memory/write-back and handshakes with a
// variable-latency memory. Outputs are a Moore decode of state, except the
// few enables that qualify on mem_ready or br_taken.
module rv32i_mc_control
  import rv32i_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               IR,
  input  logic                      br_taken,
  rv32i_mc_control_if.master        mem,
  output logic                      IR_Write,
  output logic                      PC_Write,
  output logic                      PC_Src,
  output logic                      RegWrite,
  output logic [2:0]                SE_Control,
  output logic [1:0]                ALU_SrcA,
  output logic [1:0]                ALU_SrcB,
  output logic [1:0]                ALU_Op,
  output logic [1:0]                WB_Sel,
  output logic                      retire,
  output logic                      illegal
);

  state_t     state;
  state_t     state_nx;
  iclass_t    iclass;
  logic [2:0] imm_fmt;
  logic       bad_op;
  logic       rd_nonzero;
  logic       is_store;
  logic       unused_ir_bits;

  // Only opcode and rd steer control; funct fields go straight to the ALU
  assign unused_ir_bits = ^IR[31:12];
  assign rd_nonzero     = |IR[11:7];
  assign is_store       = (iclass == C_STORE);

  rv32i_opcode_class u_opcode_class (
    .opcode  (IR[6:0]),
    .iclass  (iclass),
    .imm_fmt (imm_fmt),
    .bad_op  (bad_op)
  );

  // State register; reset drops straight to IDLE, abandoning any request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Sticky illegal-opcode flag, raised on the way into TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            illegal <= 1'b0;
    else if (state == S_DECODE && bad_op) illegal <= 1'b1;
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  if (mem.mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        if (bad_op)                state_nx = S_TRAP;
        else if (iclass == C_NOP)  state_nx = S_FETCH;
        else                       state_nx = S_EXEC;
      end
      S_EXEC: begin
        case (iclass)
          C_LOAD, C_STORE: state_nx = S_MEM;
          C_BRANCH:        state_nx = S_FETCH;
          default:         state_nx = S_WB;
        endcase
      end
      S_MEM:    if (mem.mem_ready) state_nx = is_store ? S_FETCH : S_WB;
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Control outputs per state; everything idles at 0 unless driven here
  always_comb begin
    mem.Mem_Req   = 1'b0;
    mem.Mem_Write = 1'b0;
    mem.IorD      = 1'b0;
    IR_Write      = 1'b0;
    PC_Write      = 1'b0;
    PC_Src        = 1'b0;
    RegWrite      = 1'b0;
    SE_Control    = SE_I;
    ALU_SrcA      = SRCA_PC;
    ALU_SrcB      = SRCB_RS2;
    ALU_Op        = ALU_ADD;
    WB_Sel        = WB_ALU;
    retire        = 1'b0;
    case (state)
      S_FETCH: begin
        // Address from PC while the ALU forms PC+4 for the same edge
        mem.Mem_Req = 1'b1;
        ALU_SrcA    = SRCA_PC;
        ALU_SrcB    = SRCB_FOUR;
        ALU_Op      = ALU_ADD;
        IR_Write    = mem.mem_ready;
        PC_Write    = mem.mem_ready;
      end
      S_DECODE: begin
        SE_Control = imm_fmt;
        retire     = (iclass == C_NOP);
      end
      S_EXEC: begin
        SE_Control = imm_fmt;
        case (iclass)
          C_R: begin
            ALU_SrcA = SRCA_RS1;
            ALU_SrcB = SRCB_RS2;
            ALU_Op   = ALU_FUNCT;
          end
          C_IALU: begin
            ALU_SrcA = SRCA_RS1;
            ALU_SrcB = SRCB_IMM;
            ALU_Op   = ALU_FUNCT;
          end
          C_LOAD, C_STORE: begin
            ALU_SrcA = SRCA_RS1;
            ALU_SrcB = SRCB_IMM;
          end
          C_BRANCH: begin
            // ALU forms OldPC+imm; the comparator resolves br_taken alongside
            ALU_SrcA = SRCA_OLDPC;
            ALU_SrcB = SRCB_IMM;
            ALU_Op   = ALU_CMP;
            PC_Src   = 1'b1;
            PC_Write = br_taken;
            retire   = 1'b1;
          end
          C_JAL: begin
            ALU_SrcA = SRCA_OLDPC;
            ALU_SrcB = SRCB_IMM;
            PC_Src   = 1'b1;
            PC_Write = 1'b1;
          end
          C_JALR: begin
            // Datapath clears bit 0 of the target on the PC_Src=1 path
            ALU_SrcA = SRCA_RS1;
            ALU_SrcB = SRCB_IMM;
            PC_Src   = 1'b1;
            PC_Write = 1'b1;
          end
          C_LUI: begin
            ALU_SrcA = SRCA_ZERO;
            ALU_SrcB = SRCB_IMM;
          end
          C_AUIPC: begin
            ALU_SrcA = SRCA_OLDPC;
            ALU_SrcB = SRCB_IMM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address, direction and request held steady until mem_ready
        SE_Control    = imm_fmt;
        mem.Mem_Req   = 1'b1;
        mem.IorD      = 1'b1;
        mem.Mem_Write = is_store;
        retire        = is_store & mem.mem_ready;
      end
      S_WB: begin
        SE_Control = imm_fmt;
        RegWrite   = rd_nonzero;
        retire     = 1'b1;
        case (iclass)
          C_LOAD:         WB_Sel = WB_MEM;
          C_JAL, C_JALR:  WB_Sel = WB_LINK;
          default:        WB_Sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

endmodule
